// File: rtl/shared_pkg.sv
// Shared definitions for the FIFO write arbiter: arbiter state encoding,
// default geometry, and the counter type used by verification code.
package shared_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int OVF_CNT_W      = 8;

    // Encoding 2'd3 is never entered; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_ACTIVE   = 2'd1,
        ARB_THROTTLE = 2'd2
    } arb_state_e;

    // Verification check/error counters.
    typedef int unsigned chk_count_t;

    // Width of an index into n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: selects the first set bit of valid, scanning upward
// from rr_ptr and wrapping modulo NUM_REQ. Purely combinational.
module rr_priority_picker
    import shared_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand_idx;

    // Scan candidates in rotated order; first valid one wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && valid[cand_idx]) begin
                found              = 1'b1;
                grant_idx          = cand_idx;
                grant_oh[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Grants are combinational (req_ready); the FIFO write strobe and data are
// registered one cycle after the transfer. Grants are withheld while the
// FIFO is full, or almost full with a write already in flight.
module fifo_wr_arbiter
    import shared_pkg::*;
#(
    parameter  int NUM_REQ    = NUM_REQ_DEF,
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int IDX_W      = idx_width(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic                                 fifo_full,
    input  logic                                 fifo_almostfull,
    input  logic                                 fifo_overflow,
    output logic                                 fifo_wr_en,
    output logic [DATA_WIDTH-1:0]                fifo_data_in,
    output logic [1:0]                           state_o,
    output logic [OVF_CNT_W-1:0]                 overflow_cnt
);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [OVF_CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;

    logic                   any_valid;
    logic                   blocked;
    logic                   grant_en;
    logic [NUM_REQ-1:0]     pick_oh;
    logic [IDX_W-1:0]       pick_idx;

    // A write already in flight counts against an almost-full FIFO.
    assign any_valid = |req_valid;
    assign blocked   = fifo_full | (fifo_almostfull & wr_en_q);
    // rst_n gates the grant so req_ready is low throughout reset.
    assign grant_en  = rst_n & any_valid & ~blocked;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_d = ARB_IDLE;
        case (state_q)
            ARB_IDLE: begin
                if (any_valid) state_d = blocked ? ARB_THROTTLE : ARB_ACTIVE;
                else           state_d = ARB_IDLE;
            end
            ARB_ACTIVE: begin
                if (!any_valid)   state_d = ARB_IDLE;
                else if (blocked) state_d = ARB_THROTTLE;
                else              state_d = ARB_ACTIVE;
            end
            ARB_THROTTLE: begin
                if (blocked)        state_d = ARB_THROTTLE;
                else if (any_valid) state_d = ARB_ACTIVE;
                else                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // FSM outputs: state visibility and the combinational grant.
    always_comb begin
        state_o   = state_q;
        req_ready = grant_en ? pick_oh : '0;
    end

    // Next values for pointer, write strobe/data and overflow counter.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = grant_en;
        data_d    = data_q;
        ovf_cnt_d = ovf_cnt_q;
        if (grant_en) begin
            rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
            data_d   = req_data[pick_idx];
        end
        if (fifo_overflow && (ovf_cnt_q != {OVF_CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            data_q    <= '0;
            ovf_cnt_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            data_q    <= data_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign overflow_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model every cycle.
module tb_fifo_wr_arbiter;
    import shared_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0][W-1:0] req_data;
    logic [N-1:0]        req_ready;
    logic                fifo_full, fifo_almostfull, fifo_overflow;
    logic                fifo_wr_en;
    logic [W-1:0]        fifo_data_in;
    logic [1:0]          state_o;
    logic [7:0]          overflow_cnt;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_overflow   (fifo_overflow),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_data_in    (fifo_data_in),
        .state_o         (state_o),
        .overflow_cnt    (overflow_cnt)
    );

    chk_count_t checks = 0;
    chk_count_t errors = 0;

    // Reference model state
    int         m_state, m_ptr, m_wr, m_ovf, m_grant;
    logic [W-1:0] m_data;
    int         grant_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_wr = 0; m_data = '0; m_ovf = 0;
    endtask

    function automatic int model_pick();
        if (!rst_n || req_valid == '0) return -1;
        if (fifo_full || (fifo_almostfull && m_wr != 0)) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle: inputs are already applied; check at negedge, advance model.
    task automatic cycle();
        bit any, blk;
        @(negedge clk);
        m_grant = model_pick();
        chk("req_ready", 32'(req_ready), (m_grant >= 0) ? (32'd1 << m_grant) : 32'd0);
        chk("wr_en",     32'(fifo_wr_en), 32'(m_wr));
        chk("data_in",   32'(fifo_data_in), 32'(m_data));
        chk("state",     32'(state_o), 32'(m_state));
        chk("ovf_cnt",   32'(overflow_cnt), 32'(m_ovf));
        chk("rr_ptr",    32'(dut.rr_ptr_q), 32'(m_ptr));
        if (m_grant >= 0) grant_log.push_back(m_grant);
        if (!rst_n) begin
            model_reset();
        end else begin
            any = (req_valid != '0);
            blk = fifo_full || (fifo_almostfull && m_wr != 0);
            case (m_state)
                0: if (any) m_state = blk ? 2 : 1;
                1: if (!any) m_state = 0; else if (blk) m_state = 2;
                default: if (!blk) m_state = any ? 1 : 0;
            endcase
            if (m_grant >= 0) begin
                m_wr   = 1;
                m_data = req_data[m_grant];
                m_ptr  = (m_grant + 1) % N;
            end else begin
                m_wr = 0;
            end
            if (fifo_overflow && m_ovf < 255) m_ovf++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) req_data[i] = W'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_data = '0;
        fifo_full = 1'b0; fifo_almostfull = 1'b0; fifo_overflow = 1'b0;
        model_reset();
        @(posedge clk); #1;
        cycle(); cycle();
        rst_n = 1'b1;

        // All four requesting: strict rotation from index 0.
        grant_log.delete();
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin rand_data(); cycle(); end
        chk("rot_len", 32'(grant_log.size()), 32'd8);
        for (int c = 0; c < 8 && c < grant_log.size(); c++) chk("rot_order", 32'(grant_log[c]), 32'(c % 4));
        req_valid = '0; cycle();

        // Two sparse requesters alternate; pointer lands past index 2.
        grant_log.delete();
        req_valid = 4'b0101;
        rand_data(); cycle(); rand_data(); cycle();
        chk("ptr_after_2", 32'(dut.rr_ptr_q), 32'd3);
        rand_data(); cycle(); rand_data(); cycle();
        for (int c = 0; c < 4 && c < grant_log.size(); c++) chk("alt_order", 32'(grant_log[c]), (c % 2 == 0) ? 32'd0 : 32'd2);

        // Almost-full with a write in flight throttles, then recovers.
        req_valid = 4'b1111; rand_data(); cycle();
        fifo_almostfull = 1'b1; rand_data(); cycle();
        chk("throttle", 32'(state_o), 32'd2);
        fifo_almostfull = 1'b0; rand_data(); cycle();
        chk("recover", 32'(state_o), 32'd1);

        // Full for 5 cycles with only requester 1.
        req_valid = 4'b0010; fifo_full = 1'b1;
        grant_log.delete();
        for (int c = 0; c < 5; c++) begin rand_data(); cycle(); end
        chk("full_nogrant", 32'(grant_log.size()), 32'd0);
        fifo_full = 1'b0; rand_data(); cycle();
        chk("full_release", (grant_log.size() == 1) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'd1);

        // Overflow counter saturation.
        req_valid = '0; fifo_overflow = 1'b1;
        for (int c = 0; c < 300; c++) cycle();
        chk("ovf_sat", 32'(overflow_cnt), 32'd255);
        fifo_overflow = 1'b0;

        // Reset mid-transfer.
        req_valid = 4'b1111; rand_data(); cycle();
        rst_n = 1'b0; model_reset();
        #1;
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_ovf", 32'(overflow_cnt), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        cycle();
        rst_n = 1'b1;
        grant_log.delete();
        req_valid = 4'b1100; rand_data(); cycle();
        chk("post_rst_grant", (grant_log.size() == 1) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'd2);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            req_valid       = N'($urandom_range(0, 15));
            fifo_full       = ($urandom_range(0, 7) == 0);
            fifo_almostfull = ($urandom_range(0, 3) == 0);
            fifo_overflow   = ($urandom_range(0, 7) == 0);
            rand_data();
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters sharing the FIFO write port.
REQ-002 Parameter DATA_WIDTH, default 16, FIFO data word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester write request.
REQ-006 req_data  input  NUM_REQ x DATA_WIDTH  per-requester write word.
REQ-007 req_ready  output  NUM_REQ  one-hot grant pulse; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 fifo_full, fifo_almostfull, fifo_overflow  input  1 each  status from the FIFO.
REQ-009 fifo_wr_en  output  1  registered write strobe to the FIFO.
REQ-010 fifo_data_in  output  DATA_WIDTH  registered write data to the FIFO.
REQ-011 state_o  output  2  current FSM state, for the bench.
REQ-012 overflow_cnt  output  8  saturating count of fifo_overflow pulses.

Function
REQ-013 FSM states: IDLE=0, ACTIVE=1, THROTTLE=2; the encoding 3 shall be unreachable and shall recover to IDLE on the next edge.
REQ-014 IDLE->ACTIVE when any req_valid is high and the grant is not blocked; IDLE->THROTTLE when any req_valid is high and the grant is blocked.
REQ-015 ACTIVE->IDLE when no req_valid is high; ACTIVE->THROTTLE when the grant is blocked.
REQ-016 THROTTLE->ACTIVE when the grant is unblocked and any req_valid is high; THROTTLE->IDLE when the grant is unblocked and no req_valid is high.
REQ-017 The grant is blocked when fifo_full=1, or when fifo_almostfull=1 and fifo_wr_en=1 (a write is in flight).
REQ-018 When unblocked, the block shall assert req_ready combinationally to exactly one valid requester per cycle.
REQ-019 Requester selection shall be round-robin, scanning from rr_ptr upward modulo NUM_REQ.
REQ-020 After each grant of index g, rr_ptr shall become (g+1) mod NUM_REQ; rr_ptr shall be unchanged in cycles with no grant.
REQ-021 Latency: a transfer in cycle N shall produce fifo_wr_en=1 and fifo_data_in=req_data[g] in cycle N+1.
REQ-022 fifo_wr_en shall be 0 in any cycle following a cycle without a transfer.
REQ-023 fifo_data_in shall hold its last value when fifo_wr_en=0.
REQ-024 req_ready shall be all-zero while blocked, while no req_valid is high, and during reset.
REQ-025 A requester holding req_valid continuously shall be granted within NUM_REQ unblocked cycles.
REQ-026 overflow_cnt shall increment by 1 on each cycle with fifo_overflow=1, and shall saturate at 255.
REQ-027 A requester that drops req_valid without being granted loses nothing and shall not affect rr_ptr.

Reset
REQ-028 Asserting rst_n=0 shall immediately force: state IDLE, rr_ptr=0, fifo_wr_en=0, fifo_data_in=0, overflow_cnt=0, req_ready=0.
REQ-029 Reset asserted mid-operation shall discard any in-flight write; the cycle after rst_n rises shall show fifo_wr_en=0.
REQ-030 The first grant after reset shall go to the lowest-index valid requester.

Structure
REQ-031 The arbiter state enum typedef and the NUM_REQ/DATA_WIDTH defaults shall live in shared_pkg alongside the existing verification counters.
REQ-032 Round-robin selection shall be a combinational sub-module rr_priority_picker (inputs: valid vector, rr_ptr; output: one-hot grant, grant index).
REQ-033 All outputs except req_ready shall be driven from registers.

Verification
REQ-034 After reset, req_valid=4'b1111 held for 8 cycles with the FIFO not full -> grants in the order 0,1,2,3,0,1,2,3; fifo_wr_en high on cycles 2-9.
REQ-035 req_valid=4'b0101 -> grants alternate 0,2,0,2; rr_ptr after a grant of 2 is 3.
REQ-036 fifo_almostfull=1 while fifo_wr_en=1 -> req_ready=0 and state THROTTLE; fifo_almostfull dropped -> ACTIVE next cycle.
REQ-037 fifo_full=1 held for 5 cycles with req_valid=4'b0010 -> no req_ready and no fifo_wr_en for 5 cycles; requester 1 granted on the first unblocked cycle.
REQ-038 300 cycles of fifo_overflow=1 -> overflow_cnt=255 and no wrap.
REQ-039 rst_n pulsed low during an active transfer cycle -> fifo_wr_en=0 and overflow_cnt=0 immediately, then the next grant goes to the lowest valid index.
